systolic_array_ctrl: RTL

SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

---
 rtl/systolic_array_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/systolic_array_ctrl.sv
// rtl/systolic_array_ctrl.sv - Feeds a systolic array from an activation buffer with per-row skew.
// Sequences buffer reads, skews lanes by row index and counts column outputs to detect job completion.
module systolic_array_ctrl #(
  parameter int ROWS  = 32,
  parameter int COLS  = 32,
  parameter int LEN_W = 16,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [RW-1:0]      cfg_last_row,
  input  logic [CW-1:0]      cfg_last_col,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               act_rd_en,
  output logic [LEN_W-1:0]   act_rd_addr,
  input  logic [ROWS*16-1:0] act_rd_data,
  output logic [ROWS*16-1:0] array_act,
  output logic [ROWS-1:0]    array_act_valid,
  output logic [RW-1:0]      last_row,
  output logic [CW-1:0]      last_col,
  input  logic [COLS-1:0]    psum_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] out_cnt;
  logic             rd_en_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_q       <= '0;
      out_cnt     <= '0;
      rd_en_d     <= 1'b0;
      act_rd_en   <= 1'b0;
      act_rd_addr <= '0;
      last_row    <= '0;
      last_col    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      out_cnt     <= '0;
      rd_en_d     <= 1'b0;
      act_rd_en   <= 1'b0;
      act_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      rd_en_d <= act_rd_en;
      done    <= 1'b0;
      // Output counter saturates so late psum pulses cannot overrun the job length.
      if ((state == FEED || state == DRAIN) && psum_valid[last_col] && out_cnt != len_q)
        out_cnt <= out_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            last_row    <= cfg_last_row;
            last_col    <= cfg_last_col;
            len_q       <= cfg_len;
            out_cnt     <= '0;
            act_rd_addr <= '0;
            busy        <= 1'b1;
            if (cfg_len != '0) begin
              state     <= FEED;
              act_rd_en <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        FEED: begin
          if (act_rd_addr == len_q - 1'b1) begin
            act_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            act_rd_addr <= act_rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (out_cnt == len_q) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row r holds r+1 stages; inactive rows are zeroed at entry so the last stage is the output.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [15:0] dsh [0:r];
    logic        vsh [0:r];
    logic        lane_on;

    assign lane_on = (RW'(r) <= last_row);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= r; k++) begin
          dsh[k] <= '0;
          vsh[k] <= 1'b0;
        end
      end else if (abort) begin
        for (int k = 0; k <= r; k++) begin
          dsh[k] <= '0;
          vsh[k] <= 1'b0;
        end
      end else begin
        dsh[0] <= (rd_en_d && lane_on) ? act_rd_data[r*16 +: 16] : 16'h0;
        vsh[0] <= rd_en_d && lane_on;
        for (int k = 1; k <= r; k++) begin
          dsh[k] <= dsh[k-1];
          vsh[k] <= vsh[k-1];
        end
      end
    end

    assign array_act[r*16 +: 16] = dsh[r];
    assign array_act_valid[r]    = vsh[r];
  end

endmodule
